// File: rtl/riscv_pkg.sv
// Shared fetch/decode definitions: NOP encoding, fetch FSM states,
// instruction-buffer entry layout and opcode constants used by the decoder.
package riscv_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer holding {pc, instr} pairs; flush wins over push and pop.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  fetch_entry_t  wr_data,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         unique case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= wr_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word fetches, buffers responses with their PCs
// for decode, and handles branch redirects by flushing and draining stale responses.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   fetch_state_t  state;
   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] outstanding_next;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] count;
   logic [CW:0]   credit_used;
   logic [31:0]   redirect_pc;
   fetch_entry_t  head;
   fetch_entry_t  wr_data;
   logic          xfer;
   logic          resp;
   logic          push;
   logic          pop;
   logic          unused_redirect_bits;

   assign redirect_pc          = {i_redirect_pc[31:2], 2'b00};
   assign unused_redirect_bits = ^i_redirect_pc[1:0];

   assign o_valid = (count != '0);
   assign o_instr = o_valid ? head.instr : NOP_INSTR;
   assign o_pc    = o_valid ? head.pc    : '0;

   // An entry leaving this cycle frees its credit now, which is what lets a
   // single-cycle memory sustain one instruction per cycle with two entries.
   assign credit_used = {1'b0, outstanding} + {1'b0, count}
                      - (CW + 1)'(o_valid & i_ready);
   assign o_imem_req  = (state == FETCH) && (credit_used < (CW + 1)'(FIFO_DEPTH));
   assign o_imem_addr = fetch_pc;

   assign xfer = o_imem_req & i_imem_gnt;
   assign resp = i_imem_rvalid & (outstanding != '0);
   assign push = resp & (state == FETCH) & ~i_redirect;
   assign pop  = o_valid & i_ready & ~i_redirect;

   assign outstanding_next = outstanding + CW'(xfer) - CW'(resp);
   assign wr_data          = '{pc: resp_pc, instr: i_imem_rdata};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= BOOT;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_next;
         unique case (state)
            BOOT: begin
               state <= FETCH;
               if (i_redirect) begin
                  fetch_pc <= redirect_pc;
                  resp_pc  <= redirect_pc;
               end
            end
            FETCH: begin
               if (i_redirect) begin
                  // Everything still owed by memory after this edge is stale.
                  fetch_pc <= redirect_pc;
                  resp_pc  <= redirect_pc;
                  drop_cnt <= outstanding_next;
                  state    <= (outstanding_next != '0) ? DRAIN : FETCH;
               end else begin
                  if (xfer) fetch_pc <= fetch_pc + 32'd4;
                  if (resp) resp_pc  <= resp_pc + 32'd4;
               end
            end
            DRAIN: begin
               if (i_redirect) begin
                  fetch_pc <= redirect_pc;
                  resp_pc  <= redirect_pc;
               end
               if (resp) drop_cnt <= drop_cnt - CW'(1);
               if (drop_cnt == CW'(resp)) state <= FETCH;
            end
            default: state <= BOOT;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n && i_imem_rvalid) assert (outstanding != '0);
   end

   fetch_fifo #(
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .push   (push),
      .pop    (pop),
      .flush  (i_redirect),
      .wr_data(wr_data),
      .count  (count),
      .head   (head)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model of configurable latency.
module tb_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] addr;
      int unsigned due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        gnt = 1'b1;
   logic        rvalid_m = 1'b0;
   logic        imem_rvalid;
   logic [31:0] rdata = '0;
   logic        ready = 1'b1;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        req;
   logic [31:0] addr;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        valid;

   int          checks = 0;
   int          failures = 0;
   int unsigned lat = 1;
   int unsigned cyc = 0;
   pend_t       q[$];

   assign imem_rvalid = rvalid_m & rst_n;

   fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .FIFO_DEPTH(2)
   ) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .o_imem_req   (req),
      .o_imem_addr  (addr),
      .i_imem_gnt   (gnt),
      .i_imem_rvalid(imem_rvalid),
      .i_imem_rdata (rdata),
      .o_instr      (instr),
      .o_pc         (pc),
      .o_valid      (valid),
      .i_ready      (ready),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_for(input logic [31:0] a);
      return {a[31:2], 2'b11} ^ 32'h5A00_0000;
   endfunction

   // Memory: accepts on req&gnt, answers in order `lat` cycles later; reset with the core.
   initial begin
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) begin
            q.delete();
         end else begin
            if (rvalid_m) void'(q.pop_front());
            if (req && gnt) q.push_back('{addr: addr, due: cyc + lat});
         end
         #1;
         rvalid_m = 1'b0;
         if (rst_n && q.size() > 0 && q[0].due <= cyc + 1) begin
            rvalid_m = 1'b1;
            rdata    = instr_for(q[0].addr);
         end
      end
   end

   task automatic do_reset(input int unsigned l);
      @(negedge clk);
      rst_n = 1'b0; gnt = 1'b1; ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
      lat = l;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 1'b0; redirect = 1'b0; ready = 1'b1; gnt = 1'b1; lat = 1;
      #1;
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", req); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (instr !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
      checks++; if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", pc); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL boot_no_req got=%b exp=0", req); end
      @(negedge clk); #1;
      checks++; if ({req, addr} !== {1'b1, 32'h0}) begin
         failures++; $display("FAIL first_req got=%b/%h exp=1/00000000", req, addr);
      end
   endtask

   task automatic test_stream();
      do_reset(1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         checks++; if ({req, addr} !== {1'b1, 32'(4 * i)}) begin
            failures++; $display("FAIL stream_addr[%0d] got=%b/%h exp=1/%h", i, req, addr, 32'(4 * i));
         end
         if (i >= 2) begin
            checks++; if ({valid, pc, instr} !== {1'b1, 32'(4 * (i - 2)), instr_for(32'(4 * (i - 2)))}) begin
               failures++; $display("FAIL stream_out[%0d] got=%b/%h/%h exp=1/%h/%h", i, valid, pc, instr,
                                    32'(4 * (i - 2)), instr_for(32'(4 * (i - 2))));
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset(1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ready = 1'b0;
         #1;
         checks++; if (req !== (i < 2)) begin
            failures++; $display("FAIL bp_req[%0d] got=%b exp=%b", i, req, (i < 2));
         end
         if (i >= 2) begin
            checks++; if ({valid, pc} !== {1'b1, 32'h0}) begin
               failures++; $display("FAIL bp_hold[%0d] got=%b/%h exp=1/00000000", i, valid, pc);
            end
         end
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         ready = 1'b1;
         #1;
         if (k == 0) begin
            checks++; if ({req, addr} !== {1'b1, 32'h8}) begin
               failures++; $display("FAIL bp_resume_req got=%b/%h exp=1/00000008", req, addr);
            end
         end
         checks++; if ({valid, pc, instr} !== {1'b1, 32'(4 * k), instr_for(32'(4 * k))}) begin
            failures++; $display("FAIL bp_resume[%0d] got=%b/%h/%h exp=1/%h", k, valid, pc, instr, 32'(4 * k));
         end
      end
   endtask

   task automatic test_redirect_drain();
      bit found = 0;
      bit seen_req = 0;
      bit seen_out = 0;
      do_reset(3);
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk); #1;
         if (q.size() == 2 && q[0].addr == 32'h8) found = 1;
      end
      checks++; if (!found) begin failures++; $display("FAIL drain_setup got=timeout exp=pcs 8,12 in flight"); end
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL drain_credit_req got=%b exp=0", req); end
      redirect = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL drain_valid_after got=%b exp=0", valid); end
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL drain_req got=%b exp=0", req); end
      for (int i = 0; i < 30 && !seen_out; i++) begin
         @(negedge clk); #1;
         if (req && !seen_req) begin
            seen_req = 1;
            checks++; if (addr !== 32'h100) begin failures++; $display("FAIL drain_next_addr got=%h exp=00000100", addr); end
         end
         if (valid) begin
            seen_out = 1;
            checks++; if ({pc, instr} !== {32'h100, instr_for(32'h100)}) begin
               failures++; $display("FAIL drain_first_out got=%h/%h exp=00000100/%h", pc, instr, instr_for(32'h100));
            end
         end
      end
      checks++; if (!seen_out) begin failures++; $display("FAIL drain_timeout got=no output exp=pc 00000100"); end
   endtask

   task automatic test_redirect_collision();
      bit seen_req = 0;
      bit seen_out = 0;
      do_reset(1);
      repeat (5) @(negedge clk);
      #1;
      checks++; if ({req, imem_rvalid} !== 2'b11) begin
         failures++; $display("FAIL coll_setup got=%b%b exp=11", req, imem_rvalid);
      end
      redirect = 1'b1; redirect_pc = 32'h203;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL coll_valid_after got=%b exp=0", valid); end
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL coll_drain_req got=%b exp=0", req); end
      for (int i = 0; i < 30 && !seen_out; i++) begin
         @(negedge clk); #1;
         if (req && !seen_req) begin
            seen_req = 1;
            checks++; if (addr !== 32'h200) begin failures++; $display("FAIL coll_next_addr got=%h exp=00000200", addr); end
         end
         if (valid) begin
            seen_out = 1;
            checks++; if ({pc, instr} !== {32'h200, instr_for(32'h200)}) begin
               failures++; $display("FAIL coll_first_out got=%h/%h exp=00000200/%h", pc, instr, instr_for(32'h200));
            end
         end
      end
      checks++; if (!seen_out) begin failures++; $display("FAIL coll_timeout got=no output exp=pc 00000200"); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_seq [3];
      logic [31:0] addrs [3];
      logic [31:0] pcs [3];
      int na = 0;
      int nv = 0;
      exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC; exp_seq[2] = 32'h0000_0000;
      do_reset(1);
      @(negedge clk);
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      @(negedge clk);
      redirect = 1'b0;
      for (int i = 0; i < 30 && nv < 3; i++) begin
         #1;
         if (req && gnt && na < 3) begin addrs[na] = addr; na++; end
         if (valid && ready && nv < 3) begin pcs[nv] = pc; nv++; end
         @(negedge clk);
      end
      checks++; if (nv != 3 || na != 3) begin failures++; $display("FAIL wrap_timeout got=%0d/%0d exp=3/3", na, nv); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (i < na && addrs[i] !== exp_seq[i]) begin
            failures++; $display("FAIL wrap_addr[%0d] got=%h exp=%h", i, addrs[i], exp_seq[i]);
         end
         checks++; if (i < nv && pcs[i] !== exp_seq[i]) begin
            failures++; $display("FAIL wrap_pc[%0d] got=%h exp=%h", i, pcs[i], exp_seq[i]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      bit found = 0;
      bit seen_out = 0;
      do_reset(3);
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk); #1;
         if (q.size() == 2) found = 1;
      end
      checks++; if (!found) begin failures++; $display("FAIL mid_setup got=timeout exp=2 in flight"); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if ({req, valid, instr, pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin
         failures++; $display("FAIL mid_reset_out got=%b/%b/%h/%h exp=0/0/%h/00000000", req, valid, instr, pc, NOP);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL mid_boot_req got=%b exp=0", req); end
      @(negedge clk); #1;
      checks++; if ({req, addr} !== {1'b1, 32'h0}) begin
         failures++; $display("FAIL mid_first_req got=%b/%h exp=1/00000000", req, addr);
      end
      for (int i = 0; i < 30 && !seen_out; i++) begin
         @(negedge clk); #1;
         if (valid) begin
            seen_out = 1;
            checks++; if ({pc, instr} !== {32'h0, instr_for(32'h0)}) begin
               failures++; $display("FAIL mid_first_out got=%h/%h exp=00000000/%h", pc, instr, instr_for(32'h0));
            end
         end
      end
      checks++; if (!seen_out) begin failures++; $display("FAIL mid_timeout got=no output exp=pc 00000000"); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drain();
      test_redirect_collision();
      test_wrap();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
